// File: rtl/jpeg_lift_step.sv
// CDF 5/3 reversible lifting step: predict/update, forward/inverse.
// One registered result per clock, wrapping modulo 2^WIDTH.
module jpeg_lift_step #(
  parameter int WIDTH = 16
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] left_s,
  input  logic [WIDTH-1:0] right_s,
  input  logic [WIDTH-1:0] sam_s,
  output logic [WIDTH-1:0] res_s,
  input  logic             lo_hi_s,
  input  logic             fwd_inv_s
);

  localparam int EW = WIDTH + 2;

  logic signed [EW-1:0] l_x;
  logic signed [EW-1:0] r_x;
  logic signed [EW-1:0] s_x;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] p_t;
  logic signed [EW-1:0] u_t;
  logic signed [EW-1:0] full;
  logic [WIDTH-1:0]     res_d;
  logic [WIDTH-1:0]     res_q;

  assign l_x = {{2{left_s[WIDTH-1]}}, left_s};
  assign r_x = {{2{right_s[WIDTH-1]}}, right_s};
  assign s_x = {{2{sam_s[WIDTH-1]}}, sam_s};

  // Two guard bits keep l+r+2 exact before the floor shifts.
  assign sum = l_x + r_x;
  assign p_t = sum >>> 1;
  assign u_t = (sum + EW'(2)) >>> 2;

  always_comb begin
    full = s_x;
    unique case (1'b1)
      ( fwd_inv_s && !lo_hi_s): full = s_x - p_t;
      ( fwd_inv_s &&  lo_hi_s): full = s_x + u_t;
      (!fwd_inv_s && !lo_hi_s): full = s_x + p_t;
      (!fwd_inv_s &&  lo_hi_s): full = s_x - u_t;
      default:                  full = s_x;
    endcase
    res_d = WIDTH'(full);
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res_s = res_q;

endmodule

// File: tb/tb_jpeg_lift_step.sv
// Self-checking bench for jpeg_lift_step: directed table,
// random back-to-back modes against an arithmetic model, async reset.
module tb_jpeg_lift_step;

  localparam int W = 16;

  logic         clk_fast;
  logic         rst_n;
  logic [W-1:0] left_s;
  logic [W-1:0] right_s;
  logic [W-1:0] sam_s;
  logic [W-1:0] res_s;
  logic         lo_hi_s;
  logic         fwd_inv_s;

  int errors = 0;
  int checks = 0;

  jpeg_lift_step #(.WIDTH(W)) dut (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .left_s   (left_s),
    .right_s  (right_s),
    .sam_s    (sam_s),
    .res_s    (res_s),
    .lo_hi_s  (lo_hi_s),
    .fwd_inv_s(fwd_inv_s)
  );

  initial begin
    clk_fast = 1'b0;
    forever #5 clk_fast = ~clk_fast;
  end

  typedef struct {
    string        name;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic         fwd;
    logic         hi;
    logic [W-1:0] exp;
  } vec_t;

  function automatic int fdiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [W-1:0] model(logic [W-1:0] l, logic [W-1:0] r,
                                         logic [W-1:0] s, logic fwd,
                                         logic hi);
    int li, ri, si, p, u, res;
    li = int'($signed(l));
    ri = int'($signed(r));
    si = int'($signed(s));
    p  = fdiv(li + ri, 2);
    u  = fdiv(li + ri + 2, 4);
    if (fwd && !hi)      res = si - p;
    else if (fwd && hi)  res = si + u;
    else if (!fwd && !hi) res = si + p;
    else                 res = si - u;
    return res[W-1:0];
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [W-1:0] l, logic [W-1:0] r, logic [W-1:0] s,
                       logic fwd, logic hi);
    left_s    = l;
    right_s   = r;
    sam_s     = s;
    fwd_inv_s = fwd;
    lo_hi_s   = hi;
  endtask

  vec_t vt[$];

  initial begin
    logic [W-1:0] l, r, s, exp_prev, fwd_res;
    logic         f, h;

    rst_n = 1'b1;
    drive(16'd10, 16'd20, 16'd50, 1'b1, 1'b0);
    @(negedge clk_fast);
    @(posedge clk_fast); #1;
    chk("pre_reset", res_s, 16'd35);

    // async reset: mid-cycle, no edge in between
    #2 rst_n = 1'b0;
    drive(16'h1234, 16'h0F0F, 16'h7777, 1'b1, 1'b1);
    #1 chk("reset_async", res_s, 16'h0000);
    @(posedge clk_fast); #1;
    chk("reset_hold", res_s, 16'h0000);
    @(negedge clk_fast);
    rst_n = 1'b1;
    drive(16'd10, 16'd20, 16'd50, 1'b1, 1'b0);
    @(posedge clk_fast); #1;
    chk("reset_release", res_s, 16'd35);
    @(negedge clk_fast);

    vt.push_back('{"fwd_pred",    16'd10,   16'd20,   16'd50,   1, 0, 16'd35});
    vt.push_back('{"fwd_upd",     16'd10,   16'd20,   16'd50,   1, 1, 16'd58});
    vt.push_back('{"inv_pred",    16'd10,   16'd20,   16'd35,   0, 0, 16'd50});
    vt.push_back('{"inv_upd",     16'd10,   16'd20,   16'd58,   0, 1, 16'd50});
    vt.push_back('{"neg_fpred",   16'hFFFD, 16'h0000, 16'h0000, 1, 0, 16'h0002});
    vt.push_back('{"neg_fupd",    16'hFFFD, 16'h0000, 16'h0000, 1, 1, 16'hFFFF});
    vt.push_back('{"neg_ipred",   16'hFFFD, 16'h0000, 16'h0000, 0, 0, 16'hFFFE});
    vt.push_back('{"neg_iupd",    16'hFFFD, 16'h0000, 16'h0000, 0, 1, 16'h0001});
    vt.push_back('{"wrap_fupd",   16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 1, 16'hBFFF});
    vt.push_back('{"wrap_iupd",   16'h7FFF, 16'h7FFF, 16'hBFFF, 0, 1, 16'h7FFF});
    vt.push_back('{"min_fpred",   16'h8000, 16'h8000, 16'h8000, 1, 0, 16'h0000});
    vt.push_back('{"min_fupd",    16'h8000, 16'h8000, 16'h0000, 1, 1, 16'hC000});

    foreach (vt[i]) begin
      drive(vt[i].l, vt[i].r, vt[i].s, vt[i].fwd, vt[i].hi);
      @(posedge clk_fast); #1;
      chk(vt[i].name, res_s, vt[i].exp);
      @(negedge clk_fast);
    end

    // back-to-back, all four modes rotating, checked every cycle
    drive(16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    exp_prev = 16'd0;
    for (int i = 0; i < 200; i++) begin
      l = W'($urandom);
      r = W'($urandom);
      s = W'($urandom);
      f = (i % 4) < 2;
      h = i[0];
      drive(l, r, s, f, h);
      @(posedge clk_fast); #1;
      chk("b2b", res_s, model(l, r, s, f, h));
      if (i == 120) begin
        #1 rst_n = 1'b0;
        #1 chk("midrst_async", res_s, 16'h0000);
        @(posedge clk_fast); #1;
        chk("midrst_hold", res_s, 16'h0000);
        @(negedge clk_fast);
        rst_n = 1'b1;
      end else begin
        @(negedge clk_fast);
      end
    end

    // random forward then inverse round trip
    for (int i = 0; i < 40; i++) begin
      l = W'($urandom);
      r = W'($urandom);
      s = W'($urandom);
      h = i[0];
      drive(l, r, s, 1'b1, h);
      @(posedge clk_fast); #1;
      fwd_res = model(l, r, s, 1'b1, h);
      chk("rt_fwd", res_s, fwd_res);
      @(negedge clk_fast);
      drive(l, r, fwd_res, 1'b0, h);
      @(posedge clk_fast); #1;
      chk("rt_inv", res_s, s);
      @(negedge clk_fast);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
